// File: rtl/cache_mem_if.sv
// Cache <-> memory responder bus: read request/return channel and write channel.
// The cache drives the master side; the responder implements the slave side.
interface cache_mem_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;

  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output wr_rdy
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache refill/writeback: word-addressed RAM in four
// word-lane banks, one-cycle write commit, fixed-latency beat-per-cycle read return.
//
// state   | meaning
// --------+-------------------------------------------------------------
// W_IDLE  | no write held; wr_rdy asserted
// W_BUSY  | latched write commits to the banks at the next edge
// R_IDLE  | no read in flight; rd_rdy asserted unless a write is pending
// R_WAIT  | latency down-counter running before the first beat
// R_BURST | one beat per edge until the beat counter reaches zero
module cache_mem_responder #(
  parameter int MEM_AW     = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_g,
  input  logic        resetn,
  cache_mem_if.slave  bus
);

  localparam int ROW_W = MEM_AW - 2;
  localparam int DEPTH = 1 << ROW_W;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic       {W_IDLE, W_BUSY}          w_state_t;

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;

  logic [31:0] mem_bank [4][DEPTH];

  logic             w_line;
  logic [ROW_W-1:0] w_row;
  logic [1:0]       w_lane;
  logic [3:0]       w_strb;
  logic [127:0]     w_data;

  logic [ROW_W-1:0] r_row;
  logic [1:0]       r_lane;
  logic [2:0]       beat_cnt;
  logic [3:0]       lat_cnt;

  logic        ret_valid_q;
  logic        ret_last_q;
  logic [31:0] ret_data_q;

  logic wr_accept;
  logic rd_accept;
  logic rd_is_line;
  logic beat_issue;
  logic unused_bits;

  assign bus.wr_rdy = resetn & (w_state == W_IDLE);
  assign bus.rd_rdy = resetn & (r_state == R_IDLE) & (w_state == W_IDLE) & ~bus.wr_req;

  assign wr_accept  = bus.wr_req & bus.wr_rdy;
  assign rd_accept  = bus.rd_req & bus.rd_rdy;
  assign rd_is_line = (bus.rd_type == TYPE_LINE);

  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_last  = ret_last_q;
  assign bus.ret_data  = ret_data_q;

  // Address bits above the RAM and below word granularity alias away.
  assign unused_bits = ^{bus.rd_addr[31:MEM_AW+2], bus.rd_addr[1:0],
                         bus.wr_addr[31:MEM_AW+2], bus.wr_addr[1:0]};

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (wr_accept) w_state_nxt = W_BUSY;
      W_BUSY:  w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    beat_issue  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (rd_accept) r_state_nxt = (RD_LATENCY == 1) ? R_BURST : R_WAIT;
      end
      // Leave on the edge that takes the counter to zero so the first beat
      // lands exactly RD_LATENCY edges after the accept.
      R_WAIT: begin
        if (lat_cnt == 4'd1) r_state_nxt = R_BURST;
      end
      // One idle pass after the last beat keeps rd_rdy low while ret_last shows.
      R_BURST: begin
        if (beat_cnt != 3'd0) beat_issue  = 1'b1;
        else                  r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_g or negedge resetn) begin
    if (!resetn) begin
      w_state     <= W_IDLE;
      r_state     <= R_IDLE;
      w_line      <= 1'b0;
      w_row       <= '0;
      w_lane      <= 2'd0;
      w_strb      <= 4'd0;
      w_data      <= '0;
      r_row       <= '0;
      r_lane      <= 2'd0;
      beat_cnt    <= 3'd0;
      lat_cnt     <= 4'd0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= 32'd0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;

      if (wr_accept) begin
        w_line <= (bus.wr_type == TYPE_LINE);
        w_row  <= bus.wr_addr[MEM_AW+1:4];
        w_lane <= bus.wr_addr[3:2];
        w_strb <= bus.wr_wstrb;
        w_data <= bus.wr_data;
      end

      if (rd_accept) begin
        r_row    <= bus.rd_addr[MEM_AW+1:4];
        r_lane   <= rd_is_line ? 2'd0 : bus.rd_addr[3:2];
        beat_cnt <= rd_is_line ? 3'd4 : 3'd1;
        lat_cnt  <= 4'(RD_LATENCY - 1);
      end else if (r_state == R_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end else if (beat_issue) begin
        r_lane   <= r_lane + 2'd1;
        beat_cnt <= beat_cnt - 3'd1;
      end

      if (beat_issue) begin
        ret_valid_q <= 1'b1;
        ret_last_q  <= (beat_cnt == 3'd1);
        ret_data_q  <= mem_bank[r_lane][r_row];
      end else begin
        ret_valid_q <= 1'b0;
        ret_last_q  <= 1'b0;
      end
    end
  end

  // RAM has no reset; an async reset drops W_BUSY so no commit follows it.
  always_ff @(posedge clk_g) begin
    if (w_state == W_BUSY) begin
      for (int b = 0; b < 4; b++) begin
        if (w_line || (w_lane == 2'(b))) begin
          for (int j = 0; j < 4; j++) begin
            if (w_line || w_strb[j]) begin
              mem_bank[b][w_row][8*j +: 8] <= w_line ? w_data[32*b + 8*j +: 8]
                                                     : w_data[8*j +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder (MEM_AW=12, RD_LATENCY=2): drives and
// samples on the falling edge, expectations are hand-computed constants.
module tb_cache_mem_responder;

  logic clk_g  = 1'b0;
  logic resetn = 1'b0;

  always #5 clk_g = ~clk_g;

  cache_mem_if bus ();

  cache_mem_responder #(.MEM_AW(12), .RD_LATENCY(2)) dut (
    .clk_g  (clk_g),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                          input logic [3:0] s, input logic [127:0] d);
    int guard = 0;
    bus.wr_type  = t;
    bus.wr_addr  = a;
    bus.wr_wstrb = s;
    bus.wr_data  = d;
    bus.wr_req   = 1'b1;
    while (!bus.wr_rdy && guard < 20) begin
      @(negedge clk_g);
      guard++;
    end
    chk("wr_accept_in_time", 32'(guard < 20), 32'd1);
    @(negedge clk_g);
    bus.wr_req = 1'b0;
    chk("wr_rdy_busy", 32'(bus.wr_rdy), 32'd0);
    @(negedge clk_g);
    chk("wr_rdy_back", 32'(bus.wr_rdy), 32'd1);
  endtask

  // Returns at the falling edge just after the accept edge.
  task automatic start_read(input logic [2:0] t, input logic [31:0] a);
    int guard = 0;
    bus.rd_type = t;
    bus.rd_addr = a;
    bus.rd_req  = 1'b1;
    while (!bus.rd_rdy && guard < 20) begin
      @(negedge clk_g);
      guard++;
    end
    chk("rd_accept_in_time", 32'(guard < 20), 32'd1);
    @(negedge clk_g);
    bus.rd_req = 1'b0;
  endtask

  // Called at the falling edge after the accept edge; latency 2 means one
  // more empty cycle, then n beats, then rd_rdy back with no beat.
  task automatic expect_beats(input string tag, input int n,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    chk({tag, "_acc"}, 32'({bus.ret_valid, bus.rd_rdy}), 32'd0);
    @(negedge clk_g);
    chk({tag, "_lat"}, 32'({bus.ret_valid, bus.rd_rdy}), 32'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_g);
      chk($sformatf("%s_ctl%0d", tag, k), 32'({bus.ret_valid, bus.ret_last, bus.rd_rdy}),
          32'({1'b1, (k == n - 1), 1'b0}));
      chk($sformatf("%s_dat%0d", tag, k), bus.ret_data, d[k]);
    end
    @(negedge clk_g);
    chk({tag, "_end"}, 32'({bus.ret_valid, bus.rd_rdy}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats;
    int lasts;
    bus.rd_req   = 1'b0;
    bus.rd_type  = 3'b000;
    bus.rd_addr  = 32'd0;
    bus.wr_req   = 1'b0;
    bus.wr_type  = 3'b000;
    bus.wr_addr  = 32'd0;
    bus.wr_wstrb = 4'd0;
    bus.wr_data  = '0;

    repeat (2) @(negedge clk_g);
    chk("rst_rdys", 32'({bus.rd_rdy, bus.wr_rdy}), 32'd0);
    chk("rst_valid", 32'({bus.ret_valid, bus.ret_last}), 32'd0);
    chk("rst_data", bus.ret_data, 32'd0);
    resetn = 1'b1;
    #1;
    chk("rel_rdys", 32'({bus.rd_rdy, bus.wr_rdy}), 32'b11);
    @(negedge clk_g);
    chk("rel_rdys_cyc", 32'({bus.rd_rdy, bus.wr_rdy}), 32'b11);
    chk("rel_valid", 32'(bus.ret_valid), 32'd0);
    chk("rel_data", bus.ret_data, 32'd0);

    // Line write then line read of a different offset within the same line.
    do_write(3'b100, 32'h1C00_0010, 4'h0,
             {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000});
    start_read(3'b100, 32'h1C00_001C);
    expect_beats("line_rd", 4, 32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);

    // Partial-strobe word write merges into the existing word.
    do_write(3'b010, 32'h1C00_0014, 4'b0011, {96'd0, 32'hAABB_CCDD});
    start_read(3'b010, 32'h1C00_0014);
    expect_beats("word_rd", 1, 32'h1111_CCDD, 32'd0, 32'd0, 32'd0);
    start_read(3'b000, 32'h1C00_0017);
    expect_beats("byte_rd", 1, 32'h1111_CCDD, 32'd0, 32'd0, 32'd0);
    start_read(3'b010, 32'h0000_0014);
    expect_beats("alias_rd", 1, 32'h1111_CCDD, 32'd0, 32'd0, 32'd0);
    start_read(3'b011, 32'h1C00_0018);
    expect_beats("rsvd_rd", 1, 32'h2222_2222, 32'd0, 32'd0, 32'd0);

    // Write and read raised together: write goes first.
    bus.wr_type  = 3'b100;
    bus.wr_addr  = 32'h1C00_0020;
    bus.wr_wstrb = 4'h0;
    bus.wr_data  = {4{32'h5555_5555}};
    bus.rd_type  = 3'b100;
    bus.rd_addr  = 32'h1C00_0020;
    bus.wr_req   = 1'b1;
    bus.rd_req   = 1'b1;
    #1;
    chk("same_cyc_rdys", 32'({bus.rd_rdy, bus.wr_rdy}), 32'b01);
    @(negedge clk_g);
    bus.wr_req = 1'b0;
    chk("same_cyc_busy", 32'({bus.rd_rdy, bus.wr_rdy}), 32'b00);
    @(negedge clk_g);
    chk("same_cyc_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    @(negedge clk_g);
    bus.rd_req = 1'b0;
    expect_beats("raw_rd", 4, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555);

    // Reset lands just after beat 1 of a line read.
    start_read(3'b100, 32'h1C00_0010);
    @(negedge clk_g);
    @(negedge clk_g);
    chk("abort_b0", bus.ret_data, 32'h0000_0000);
    @(negedge clk_g);
    chk("abort_b1_valid", 32'(bus.ret_valid), 32'd1);
    chk("abort_b1", bus.ret_data, 32'h1111_CCDD);
    @(posedge clk_g);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_async_valid", 32'({bus.ret_valid, bus.ret_last}), 32'd0);
    chk("abort_async_data", bus.ret_data, 32'd0);
    chk("abort_async_rdys", 32'({bus.rd_rdy, bus.wr_rdy}), 32'd0);
    repeat (2) @(negedge clk_g);
    chk("abort_hold_valid", 32'(bus.ret_valid), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_g);
      chk($sformatf("abort_quiet%0d", i), 32'({bus.ret_valid, bus.rd_rdy}), 32'b01);
    end
    start_read(3'b010, 32'h1C00_0014);
    expect_beats("post_rst_rd", 1, 32'h1111_CCDD, 32'd0, 32'd0, 32'd0);

    // Back-to-back line reads with rd_req held.
    beats = 0;
    lasts = 0;
    bus.rd_type = 3'b100;
    bus.rd_addr = 32'h1C00_0020;
    bus.rd_req  = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      logic ev, el, er;
      @(negedge clk_g);
      ev = ((n >= 3) && (n <= 6)) || ((n >= 10) && (n <= 13));
      el = (n == 6) || (n == 13);
      er = (n == 7) || (n == 14);
      if (n == 14) bus.rd_req = 1'b0;
      chk($sformatf("b2b_ctl%0d", n), 32'({bus.ret_valid, bus.ret_last, bus.rd_rdy}),
          32'({ev, el, er}));
      if (bus.ret_valid) begin
        beats++;
        chk($sformatf("b2b_dat%0d", n), bus.ret_data, 32'h5555_5555);
      end
      if (bus.ret_last) lasts++;
    end
    @(negedge clk_g);
    chk("b2b_quiet", 32'(bus.ret_valid), 32'd0);
    chk("b2b_beats", 32'(beats), 32'd8);
    chk("b2b_lasts", 32'(lasts), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
